// File: rtl/reset_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reset_seq_pkg                                              |
// | Description : Shared types and constants for the reset sequencer: the    |
// |               sequencing state enum, default timing constants and the    |
// |               helper that sizes the single sequencing timer.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package reset_seq_pkg;

   // Sequencing states. Explicit 3-bit encoding.
   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      HOLD      = 3'd1,
      RAM_UP    = 3'd2,
      RUN       = 3'd3,
      LOST      = 3'd4,
      DCM_RST   = 3'd5
   } state_t;

   // Default timing, in cycles of the 27 MHz reference clock.
   localparam int unsigned c_DEF_LOCK_HOLD      = 1024;
   localparam int unsigned c_DEF_RAM_SETTLE     = 64;
   localparam int unsigned c_DEF_DCM_RST_CYCLES = 16;
   localparam int unsigned c_DEF_LOCK_TIMEOUT   = 65536;
   localparam int unsigned c_DEF_CNT_W          = 8;

   // One timer serves every state, so it must reach the largest terminal
   // count. The extra bit keeps headroom for the compare value of a
   // power-of-two parameter.
   function automatic int unsigned timer_width(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c,
      input int unsigned d
   );
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/reset_sequencer_sync2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync2                                                      |
// | Description : Two-flop synchronizer for a single asynchronous level.     |
// |               Both flops clear to 0 on the asynchronous reset.           |
// | Ports       : clk      - destination clock                               |
// |               rst_n    - asynchronous active-low reset                   |
// |               i_async  - asynchronous input level                        |
// |               o_sync   - input level synchronized to clk                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reset_sequencer                                            |
// | Description : Watches the DCM lock indication and releases the RAM       |
// |               interface reset, then the system reset, once lock has been |
// |               stable. Requests a DCM reset on lock loss, lock timeout or |
// |               an explicit relock request, then retries. Runs from the    |
// |               free-running reference clock, never from a DCM output.     |
// | Ports       : clock           - free-running 27 MHz reference clock      |
// |               reset_n         - asynchronous active-low reset            |
// |               locked_in       - asynchronous AND of DCM LOCKED outputs   |
// |               force_relock    - pulse: run a DCM reset cycle, no count   |
// |               count_clear     - pulse: clear lock_loss_count             |
// |               dcm_reset_req   - active-high DCM reset request            |
// |               ram_reset       - active-high RAM interface reset          |
// |               sys_reset       - active-high system logic reset           |
// |               ready           - high only while running                  |
// |               lock_loss_count - saturating count of lock losses          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned LOCK_HOLD      = c_DEF_LOCK_HOLD,
   parameter int unsigned RAM_SETTLE     = c_DEF_RAM_SETTLE,
   parameter int unsigned DCM_RST_CYCLES = c_DEF_DCM_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT   = c_DEF_LOCK_TIMEOUT,
   parameter int unsigned CNT_W          = c_DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             locked_in,
   input  logic             force_relock,
   input  logic             count_clear,
   output logic             dcm_reset_req,
   output logic             ram_reset,
   output logic             sys_reset,
   output logic             ready,
   output logic [CNT_W-1:0] lock_loss_count
);

   localparam int unsigned c_TMR_W =
      timer_width(LOCK_HOLD, RAM_SETTLE, DCM_RST_CYCLES, LOCK_TIMEOUT);

   // Terminal counts: the timer holds 0 in the first cycle of a state, so a
   // state lasting N cycles leaves when the timer reads N-1.
   localparam logic [c_TMR_W-1:0] c_HOLD_LAST    = c_TMR_W'(LOCK_HOLD - 1);
   localparam logic [c_TMR_W-1:0] c_SETTLE_LAST  = c_TMR_W'(RAM_SETTLE - 1);
   localparam logic [c_TMR_W-1:0] c_DCM_LAST     = c_TMR_W'(DCM_RST_CYCLES - 1);
   localparam logic [c_TMR_W-1:0] c_TIMEOUT_LAST = c_TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   c_CNT_MAX      = '1;

   logic               w_locked_s;
   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_TMR_W-1:0] r_timer;

   logic               r_dcm_req;
   logic               r_ram_rst;
   logic               r_sys_rst;
   logic               r_ready;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_dcm_req_nxt;
   logic               w_ram_rst_nxt;
   logic               w_sys_rst_nxt;
   logic               w_ready_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;

   // locked_in is asynchronous to clock; this is its only sampling point.
   sync2 u_lock_sync (
      .clk     (clock),
      .rst_n   (reset_n),
      .i_async (locked_in),
      .o_sync  (w_locked_s)
   );

   // ------------------------------------------------------------------
   // State register. Outputs are registered alongside the state from
   // values decoded off the next state, so they change on the very edge
   // that enters the new state.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= WAIT_LOCK;
         r_timer   <= '0;
         r_dcm_req <= 1'b0;
         r_ram_rst <= 1'b1;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         // Restart timing on every transition. In RUN the timer is unused,
         // so letting it wrap there is harmless.
         if (w_state_nxt != r_state) begin
            r_timer <= '0;
         end else begin
            r_timer <= r_timer + c_TMR_W'(1);
         end
         r_dcm_req <= w_dcm_req_nxt;
         r_ram_rst <= w_ram_rst_nxt;
         r_sys_rst <= w_sys_rst_nxt;
         r_ready   <= w_ready_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic.
   // In RAM_UP and RUN a lock loss outranks force_relock so the loss is
   // always counted; elsewhere force_relock outranks everything except
   // DCM_RST, which ignores it to keep the request pulse width fixed.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_LOCK: begin
            if (force_relock) begin
               w_state_nxt = DCM_RST;
            end else if (w_locked_s) begin
               w_state_nxt = HOLD;
            end else if (r_timer == c_TIMEOUT_LAST) begin
               w_state_nxt = DCM_RST;
            end
         end
         HOLD: begin
            if (force_relock) begin
               w_state_nxt = DCM_RST;
            end else if (!w_locked_s) begin
               // Lock glitch before anything was released: just start over.
               w_state_nxt = WAIT_LOCK;
            end else if (r_timer == c_HOLD_LAST) begin
               w_state_nxt = RAM_UP;
            end
         end
         RAM_UP: begin
            if (!w_locked_s) begin
               w_state_nxt = LOST;
            end else if (force_relock) begin
               w_state_nxt = DCM_RST;
            end else if (r_timer == c_SETTLE_LAST) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (!w_locked_s) begin
               w_state_nxt = LOST;
            end else if (force_relock) begin
               w_state_nxt = DCM_RST;
            end
         end
         LOST: begin
            w_state_nxt = DCM_RST;
         end
         DCM_RST: begin
            if (r_timer == c_DCM_LAST) begin
               w_state_nxt = WAIT_LOCK;
            end
         end
         default: begin
            w_state_nxt = WAIT_LOCK;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode from the next state.
   // ram_reset is released only in RAM_UP/RUN and sys_reset only in RUN,
   // so sys_reset can never be low while ram_reset is high, and both
   // reassert together on the edge leaving RAM_UP/RUN.
   // ------------------------------------------------------------------
   always_comb begin
      w_dcm_req_nxt = (w_state_nxt == DCM_RST);
      w_ram_rst_nxt = !((w_state_nxt == RAM_UP) || (w_state_nxt == RUN));
      w_sys_rst_nxt = (w_state_nxt != RUN);
      w_ready_nxt   = (w_state_nxt == RUN);

      // LOST is entered only from RAM_UP/RUN and lasts one cycle, so
      // next-state LOST marks exactly one loss. Clear takes priority.
      w_cnt_nxt = r_cnt;
      if (count_clear) begin
         w_cnt_nxt = '0;
      end else if ((w_state_nxt == LOST) && (r_cnt != c_CNT_MAX)) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   assign dcm_reset_req   = r_dcm_req;
   assign ram_reset       = r_ram_rst;
   assign sys_reset       = r_sys_rst;
   assign ready           = r_ready;
   assign lock_loss_count = r_cnt;

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_reset_sequencer                                         |
// | Description : Self-checking bench for reset_sequencer with small timing  |
// |               parameters: directed scenarios with fixed expected edges   |
// |               plus randomized lock/relock/clear traffic compared against |
// |               a countdown-based behavioural model.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_reset_sequencer;

   localparam int T_LH = 8;
   localparam int T_RS = 4;
   localparam int T_DC = 3;
   localparam int T_TO = 32;
   localparam int T_CW = 2;
   localparam int T_CMAX = (1 << T_CW) - 1;

   // Model phases (bench-local numbering)
   localparam int PH_WAIT = 10, PH_HOLD = 11, PH_RAMUP = 12;
   localparam int PH_RUN = 13, PH_LOST = 14, PH_DCM = 15;

   logic clock = 1'b0;
   logic reset_n;
   logic locked_in;
   logic force_relock;
   logic count_clear;
   logic dcm_reset_req;
   logic ram_reset;
   logic sys_reset;
   logic ready;
   logic [T_CW-1:0] lock_loss_count;

   int n_checks = 0;
   int n_errors = 0;

   int m_ph, m_left, m_cnt;
   bit m_s1, m_s2;

   reset_sequencer #(
      .LOCK_HOLD      (T_LH),
      .RAM_SETTLE     (T_RS),
      .DCM_RST_CYCLES (T_DC),
      .LOCK_TIMEOUT   (T_TO),
      .CNT_W          (T_CW)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .locked_in       (locked_in),
      .force_relock    (force_relock),
      .count_clear     (count_clear),
      .dcm_reset_req   (dcm_reset_req),
      .ram_reset       (ram_reset),
      .sys_reset       (sys_reset),
      .ready           (ready),
      .lock_loss_count (lock_loss_count)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural reference model ----------------
   task automatic model_enter(input int p);
      m_ph = p;
      case (p)
         PH_WAIT:  m_left = T_TO;
         PH_HOLD:  m_left = T_LH;
         PH_RAMUP: m_left = T_RS;
         PH_DCM:   m_left = T_DC;
         default:  m_left = 0;
      endcase
   endtask

   task automatic model_reset();
      m_s1 = 0;
      m_s2 = 0;
      m_cnt = 0;
      model_enter(PH_WAIT);
   endtask

   // One rising edge: remaining-cycle countdown per phase, driven by the
   // two-cycle-delayed lock level.
   task automatic model_step();
      bit ls;
      int nxt;
      ls = m_s2;
      nxt = m_ph;
      case (m_ph)
         PH_WAIT:  if (force_relock) nxt = PH_DCM; else if (ls) nxt = PH_HOLD;
                   else if (m_left == 1) nxt = PH_DCM;
         PH_HOLD:  if (force_relock) nxt = PH_DCM; else if (!ls) nxt = PH_WAIT;
                   else if (m_left == 1) nxt = PH_RAMUP;
         PH_RAMUP: if (!ls) nxt = PH_LOST; else if (force_relock) nxt = PH_DCM;
                   else if (m_left == 1) nxt = PH_RUN;
         PH_RUN:   if (!ls) nxt = PH_LOST; else if (force_relock) nxt = PH_DCM;
         PH_LOST:  nxt = PH_DCM;
         default:  if (m_left == 1) nxt = PH_WAIT;
      endcase
      if (count_clear) m_cnt = 0;
      else if (nxt == PH_LOST && m_cnt < T_CMAX) m_cnt = m_cnt + 1;
      if (nxt != m_ph) model_enter(nxt);
      else m_left = m_left - 1;
      m_s2 = m_s1;
      m_s1 = locked_in;
   endtask

   function automatic logic [3:0] model_vec();
      return {m_ph == PH_DCM, !(m_ph == PH_RAMUP || m_ph == PH_RUN),
              m_ph != PH_RUN, m_ph == PH_RUN};
   endfunction

   // ---------------- stimulus plumbing ----------------
   task automatic cyc();
      @(posedge clock);
      if (reset_n) model_step();
      @(negedge clock);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      locked_in = 1'b0;
      force_relock = 1'b0;
      count_clear = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      locked_in = 1'b1;
      force_relock = 1'b0;
      count_clear = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      n_checks++;
      if ({dcm_reset_req, ram_reset, sys_reset, ready} !== 4'b0110) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b expected 0110",
                  {dcm_reset_req, ram_reset, sys_reset, ready});
      end
      n_checks++;
      if (lock_loss_count !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_count: got %0d expected 0", lock_loss_count);
      end
   endtask

   task automatic test_clean_start();
      logic [3:0] e;
      apply_reset();
      for (int c = 1; c <= 22; c++) begin
         locked_in = (c >= 5);
         cyc();
         e = {1'b0, c < 15, c < 19, c >= 19};
         n_checks++;
         if ({dcm_reset_req, ram_reset, sys_reset, ready} !== e) begin
            n_errors++;
            $display("FAIL clean_start cycle %0d: got %b expected %b", c,
                     {dcm_reset_req, ram_reset, sys_reset, ready}, e);
         end
      end
   endtask

   task automatic test_glitch_hold();
      logic [3:0] e;
      apply_reset();
      for (int c = 1; c <= 28; c++) begin
         locked_in = (c >= 5) && (c != 12);
         cyc();
         e = {1'b0, c < 23, c < 27, c >= 27};
         n_checks++;
         if ({dcm_reset_req, ram_reset, sys_reset, ready} !== e) begin
            n_errors++;
            $display("FAIL glitch_hold cycle %0d: got %b expected %b", c,
                     {dcm_reset_req, ram_reset, sys_reset, ready}, e);
         end
      end
      n_checks++;
      if (lock_loss_count !== 2'd0) begin
         n_errors++;
         $display("FAIL glitch_hold_count: got %0d expected 0", lock_loss_count);
      end
   endtask

   task automatic test_loss_run();
      logic [3:0] e;
      logic rdy;
      apply_reset();
      for (int c = 1; c <= 50; c++) begin
         locked_in = (c >= 5) && !(c >= 26 && c <= 32);
         cyc();
         rdy = (c >= 19 && c <= 27) || (c >= 47);
         e = {(c >= 29 && c <= 31), !((c >= 15 && c <= 27) || c >= 43), !rdy, rdy};
         n_checks++;
         if ({dcm_reset_req, ram_reset, sys_reset, ready} !== e) begin
            n_errors++;
            $display("FAIL loss_run cycle %0d: got %b expected %b", c,
                     {dcm_reset_req, ram_reset, sys_reset, ready}, e);
         end
         if (c == 28 || c == 50) begin
            n_checks++;
            if (lock_loss_count !== 2'd1) begin
               n_errors++;
               $display("FAIL loss_run_count cycle %0d: got %0d expected 1", c,
                        lock_loss_count);
            end
         end
      end
   endtask

   task automatic test_timeout();
      logic e;
      apply_reset();
      for (int c = 1; c <= 110; c++) begin
         cyc();
         e = (c >= 32) && (((c - 32) % 35) < 3);
         n_checks++;
         if ({dcm_reset_req, ram_reset, sys_reset, ready} !== {e, 3'b110}) begin
            n_errors++;
            $display("FAIL timeout cycle %0d: got %b expected %b", c,
                     {dcm_reset_req, ram_reset, sys_reset, ready}, {e, 3'b110});
         end
      end
      n_checks++;
      if (lock_loss_count !== 2'd0) begin
         n_errors++;
         $display("FAIL timeout_count: got %0d expected 0", lock_loss_count);
      end
   endtask

   task automatic test_saturation_clear();
      int e;
      apply_reset();
      for (int c = 1; c <= 99; c++) begin
         locked_in = (c >= 5) && !((c >= 16) && (((c - 16) % 16) < 4));
         count_clear = (c == 98);
         cyc();
         e = -1;
         if (c >= 18 && c <= 82 && ((c - 18) % 16) == 0)
            e = ((c - 18) / 16 + 1 > T_CMAX) ? T_CMAX : (c - 18) / 16 + 1;
         if (c == 97) e = 3;
         if (c >= 98) e = 0;
         if (e >= 0) begin
            n_checks++;
            if (int'(lock_loss_count) != e) begin
               n_errors++;
               $display("FAIL sat_clear_count cycle %0d: got %0d expected %0d", c,
                        lock_loss_count, e);
            end
         end
      end
      count_clear = 1'b0;
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int c = 1; c <= 32; c++) begin
         locked_in = (c >= 5) && !(c >= 16 && c <= 19);
         cyc();
      end
      n_checks++;
      if ({ram_reset, lock_loss_count} !== 3'b001) begin
         n_errors++;
         $display("FAIL async_pre: got ram=%b cnt=%0d expected ram=0 cnt=1",
                  ram_reset, lock_loss_count);
      end
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({dcm_reset_req, ram_reset, sys_reset, ready, lock_loss_count} !== 6'b011000) begin
         n_errors++;
         $display("FAIL async_ramup: got %b expected 011000",
                  {dcm_reset_req, ram_reset, sys_reset, ready, lock_loss_count});
      end
      // Second part: assert reset while the DCM request is active.
      apply_reset();
      for (int c = 1; c <= 33; c++) cyc();
      n_checks++;
      if (dcm_reset_req !== 1'b1) begin
         n_errors++;
         $display("FAIL async_pre_dcm: got %b expected 1", dcm_reset_req);
      end
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({dcm_reset_req, ram_reset, sys_reset, ready} !== 4'b0110) begin
         n_errors++;
         $display("FAIL async_dcm: got %b expected 0110",
                  {dcm_reset_req, ram_reset, sys_reset, ready});
      end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_force_relock();
      logic [3:0] e;
      bit chk;
      int ec;
      apply_reset();
      for (int c = 1; c <= 63; c++) begin
         locked_in = (c >= 5) && !(c >= 16 && c <= 19) && !(c >= 60);
         force_relock = (c == 38) || (c == 39) || (c == 62);
         cyc();
         chk = 1'b1;
         case (c)
            37, 54:        e = 4'b0001;
            38, 39, 40, 63: e = 4'b1110;
            41, 62:        e = 4'b0110;
            50, 51:        e = 4'b0010;
            default:       chk = 1'b0;
         endcase
         ec = (c >= 62) ? 2 : 1;
         if (chk) begin
            n_checks++;
            if ({dcm_reset_req, ram_reset, sys_reset, ready} !== e) begin
               n_errors++;
               $display("FAIL force_relock cycle %0d: got %b expected %b", c,
                        {dcm_reset_req, ram_reset, sys_reset, ready}, e);
            end
            n_checks++;
            if (int'(lock_loss_count) != ec) begin
               n_errors++;
               $display("FAIL force_relock_count cycle %0d: got %0d expected %0d", c,
                        lock_loss_count, ec);
            end
         end
      end
      force_relock = 1'b0;
   endtask

   task automatic test_random();
      logic [3:0] e;
      apply_reset();
      for (int c = 1; c <= 4000; c++) begin
         if (locked_in) begin
            if ($urandom_range(0, 59) == 0) locked_in = 1'b0;
         end else begin
            if ($urandom_range(0, 19) == 0) locked_in = 1'b1;
         end
         force_relock = ($urandom_range(0, 99) == 0);
         count_clear = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 999) == 0) begin
            #1 reset_n = 1'b0;
            model_reset();
            #1;
            n_checks++;
            if ({dcm_reset_req, ram_reset, sys_reset, ready, lock_loss_count} !== 6'b011000) begin
               n_errors++;
               $display("FAIL random_async cycle %0d: got %b expected 011000", c,
                        {dcm_reset_req, ram_reset, sys_reset, ready, lock_loss_count});
            end
            @(negedge clock);
            reset_n = 1'b1;
         end
         cyc();
         e = model_vec();
         n_checks++;
         if ({dcm_reset_req, ram_reset, sys_reset, ready} !== e) begin
            n_errors++;
            $display("FAIL random_outputs cycle %0d: got %b expected %b", c,
                     {dcm_reset_req, ram_reset, sys_reset, ready}, e);
         end
         n_checks++;
         if (int'(lock_loss_count) != m_cnt) begin
            n_errors++;
            $display("FAIL random_count cycle %0d: got %0d expected %0d", c,
                     lock_loss_count, m_cnt);
         end
      end
      force_relock = 1'b0;
      count_clear = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_start();
      test_glitch_hold();
      test_loss_run();
      test_timeout();
      test_saturation_clear();
      test_async_reset();
      test_force_relock();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_reset_sequencer
`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the DCM lock indications from the clock generator and produces sequenced resets for the ZBT RAM interface and for system logic.
- Drives a DCM reset request back to the clock generator on lock loss or lock timeout, then retries.
- Clocked from the free-running 27 MHz reference, never from a DCM output, because DCM outputs are invalid until lock.
- Sits between clock_gen and all logic that must be held in reset until clocks are stable.

Parameters:
LOCK_HOLD, 1024, cycles the synchronized lock must stay high before RAM reset is released
RAM_SETTLE, 64, cycles between RAM reset release and system reset release
DCM_RST_CYCLES, 16, width in cycles of the dcm_reset_req pulse
LOCK_TIMEOUT, 65536, cycles to wait for lock before forcing a DCM reset
CNT_W, 8, width of the lock-loss counter

Ports:
clock  input  1  free-running reference clock (27 MHz)
reset_n  input  1  asynchronous active-low reset
locked_in  input  1  asynchronous AND of the DCM LOCKED outputs
force_relock  input  1  one-cycle pulse; forces a DCM reset cycle without counting a loss
count_clear  input  1  one-cycle pulse; clears lock_loss_count
dcm_reset_req  output  1  active-high DCM reset request to the clock generator
ram_reset  output  1  active-high reset for the RAM interface
sys_reset  output  1  active-high reset for system logic
ready  output  1  high only in RUN
lock_loss_count  output  CNT_W  saturating count of lock losses

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- On reset_n low:
  - state=WAIT_LOCK, timer=0, synchronizer flops=0.
  - sys_reset=1, ram_reset=1, dcm_reset_req=0, ready=0, lock_loss_count=0.
- Synchronization: locked_in passes through a 2-flop synchronizer to give locked_s. No other logic samples locked_in.
- Output timing: all outputs are registered and take their new value on the same edge that enters the new state.
- Single timer: cleared on every state transition; increments otherwise. Width is $clog2 of the largest of the four cycle parameters, plus 1.
- WAIT_LOCK: sys_reset=1, ram_reset=1.
  - locked_s=1 -> HOLD.
  - timer==LOCK_TIMEOUT-1 with locked_s=0 -> DCM_RST. Timeout does not increment lock_loss_count.
- HOLD: resets stay asserted.
  - locked_s=0 -> WAIT_LOCK; this is lock glitch filtering, not counted.
  - timer==LOCK_HOLD-1 -> RAM_UP, with ram_reset=0 from that edge.
- RAM_UP: ram_reset=0, sys_reset=1.
  - locked_s=0 -> LOST.
  - timer==RAM_SETTLE-1 -> RUN.
- RUN: sys_reset=0, ram_reset=0, ready=1.
  - locked_s=0 -> LOST.
- LOST: lasts 1 cycle.
  - sys_reset=1, ram_reset=1, ready=0.
  - lock_loss_count increments, saturating at 2^CNT_W-1.
  - Next state DCM_RST.
- DCM_RST: dcm_reset_req=1, all resets asserted.
  - After exactly DCM_RST_CYCLES cycles -> WAIT_LOCK; dcm_reset_req=0 on that edge.
- force_relock:
  - In any state except DCM_RST, go directly to DCM_RST with resets asserted and no count increment.
  - Ignored while in DCM_RST.
  - If it coincides with lock loss in RAM_UP or RUN, lock loss wins: the machine goes to LOST and the loss is counted.
- count_clear: lock_loss_count=0 next edge. A simultaneous increment is discarded, so clear wins.
- Lock-loss latency: if locked_in falls before edge k, locked_s=0 after edge k+1, and sys_reset=1, ram_reset=1, ready=0 after edge k+2.
- Reset release order is guaranteed:
  - ram_reset deasserts at least RAM_SETTLE cycles before sys_reset.
  - Both assert on the same edge.
  - sys_reset is never 0 while ram_reset is 1.
- reset_n asserted mid-operation: immediate asynchronous return to reset values, including lock_loss_count=0 and dcm_reset_req=0.

Decomposition:
- Package reset_seq_pkg holds:
  - the state enum (WAIT_LOCK, HOLD, RAM_UP, RUN, LOST, DCM_RST);
  - default parameter constants;
  - a function computing the timer width.
- One sub-module, sync2: a parameterless 2-flop synchronizer with asynchronous active-low reset to 0. It is reused for other asynchronous inputs in the design.

Test Plan:
All tests use LOCK_HOLD=8, RAM_SETTLE=4, DCM_RST_CYCLES=3, LOCK_TIMEOUT=32, CNT_W=2.
1. Clean start: release reset_n, raise locked_in at cycle 5 -> ram_reset falls at cycle 15, sys_reset and ready change at cycle 19 (±0), dcm_reset_req stays 0.
2. Glitch in HOLD: drop locked_in for 1 cycle at HOLD timer=4 -> return to WAIT_LOCK, lock_loss_count stays 0, HOLD restarts from 0 after relock.
3. Loss in RUN: drop locked_in -> all resets asserted 3 edges later, lock_loss_count=1, dcm_reset_req high for exactly 3 cycles, then normal sequence repeats once locked_in returns.
4. Timeout: keep locked_in=0 -> dcm_reset_req pulses 3 cycles every 35 cycles, lock_loss_count stays 0.
5. Saturation and clear: cause 5 losses -> count reads 3. Then pulse count_clear on the same cycle as a LOST increment -> count=0.
6. Async reset in RAM_UP: assert reset_n low mid-sequence -> outputs return to reset values without waiting for a clock edge; force_relock pulse in RUN -> DCM_RST with the count unchanged.
